// File: rtl/press_counter_arbiter_pkg.sv
// press_counter_arbiter_pkg: shared FSM encoding and default constants for the press counter arbiter.
package press_counter_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_COOL = 2'd2} state_t;
   localparam int DEF_MOD  = 5;
   localparam int DEF_COOL = 2;
endpackage

// File: rtl/press_counter_arbiter_if.sv
// press_counter_arbiter_if: button inputs and counter/grant outputs of the press counter arbiter.
interface press_counter_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int CW    = 3,
   parameter int IW    = 2
);
   logic [N_REQ-1:0] req;
   logic [CW-1:0]    count;
   logic             trigger;
   logic [N_REQ-1:0] grant;
   logic [IW-1:0]    owner;
   logic             busy;
   logic             drop;
   modport master (output req, input count, trigger, grant, owner, busy, drop);
   modport slave  (input req, output count, trigger, grant, owner, busy, drop);
endinterface

// File: rtl/press_counter_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending bit at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             valid
);
   logic [2*N_REQ-1:0] rot;
   assign rot = {pending, pending} >> ptr;
   // scan downward so the smallest offset from ptr is the last (winning) assignment
   always_comb begin
      winner = '0;
      valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            winner = IW'((int'(ptr) + k) % N_REQ);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/press_counter_arbiter.sv
// press_counter_arbiter: edge-detects N_REQ buttons, queues one press each and serves them
// round-robin into a shared mod-MOD counter with a cooldown gap between grants.
module press_counter_arbiter
   import press_counter_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int MOD   = DEF_MOD,
   parameter int CW    = 3,
   parameter int COOL  = DEF_COOL,
   parameter int IW    = 2
) (
   input logic                    clk,
   input logic                    reset,
   press_counter_arbiter_if.slave bus
);
   localparam int CDW = (COOL > 1) ? $clog2(COOL) : 1;
   state_t           state;
   logic [N_REQ-1:0] req_prev;
   logic [N_REQ-1:0] pending;
   logic [IW-1:0]    rr;
   logic [CDW-1:0]   cooldown;
   logic [IW-1:0]    winner;
   logic             valid;
   logic [N_REQ-1:0] rise;
   logic [N_REQ-1:0] onehot;
   logic [N_REQ-1:0] clr;
   logic [CW-1:0]    count_n;
   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .pending(pending),
      .ptr(rr),
      .winner(winner),
      .valid(valid)
   );
   assign rise    = bus.req & ~req_prev;
   assign onehot  = N_REQ'(1) << winner;
   assign clr     = (state == ST_IDLE && valid) ? onehot : '0;
   assign count_n = (bus.count == CW'(MOD - 1)) ? '0 : bus.count + CW'(1);
   // a rise on a bit cleared this cycle is a fresh press, so only uncleared pending bits merge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         req_prev    <= '0;
         pending     <= '0;
         rr          <= '0;
         cooldown    <= '0;
         bus.count   <= '0;
         bus.trigger <= 1'b0;
         bus.grant   <= '0;
         bus.owner   <= '0;
         bus.busy    <= 1'b0;
         bus.drop    <= 1'b0;
      end else begin
         req_prev  <= bus.req;
         pending   <= (pending & ~clr) | rise;
         bus.drop  <= |(rise & pending & ~clr);
         bus.grant <= '0;
         case (state)
            ST_IDLE: if (valid) begin
               bus.grant   <= onehot;
               bus.owner   <= winner;
               bus.count   <= count_n;
               bus.trigger <= (count_n == CW'(MOD - 1));
               rr          <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
               bus.busy    <= 1'b1;
               state       <= ST_GRANT;
            end
            ST_GRANT: if (COOL > 0) begin
               cooldown <= CDW'(COOL - 1);
               state    <= ST_COOL;
            end else begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            ST_COOL: if (cooldown == '0) begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end else begin
               cooldown <= cooldown - CDW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_press_counter_arbiter.sv
// tb_press_counter_arbiter: directed vectors with hand-computed expectations for press_counter_arbiter.
module tb_press_counter_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   int hits;
   press_counter_arbiter_if #(.N_REQ(4), .CW(3), .IW(2)) bus ();
   press_counter_arbiter #(.N_REQ(4), .MOD(5), .CW(3), .COOL(2), .IW(2)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      bus.req = '0;
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
   endtask
   initial begin
      bus.req = '0;
      step(1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_trig", 32'(bus.trigger), 0);
      reset = 1'b1;
      step(1);
      // single press
      bus.req = 4'b0001;
      step(1);
      chk("single_wait", 32'(bus.grant), 0);
      step(1);
      chk("single_grant", 32'(bus.grant), 32'h1);
      chk("single_count", 32'(bus.count), 1);
      chk("single_owner", 32'(bus.owner), 0);
      chk("single_trig", 32'(bus.trigger), 0);
      chk("single_busy0", 32'(bus.busy), 1);
      bus.req = '0;
      step(1);
      chk("single_gdone", 32'(bus.grant), 0);
      chk("single_busy1", 32'(bus.busy), 1);
      step(1);
      chk("single_busy2", 32'(bus.busy), 1);
      step(1);
      chk("single_idle", 32'(bus.busy), 0);
      // five sequential presses on req[1]
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.req = 4'b0010;
         step(1);
         bus.req = '0;
         step(1);
         chk("seq_grant", 32'(bus.grant), 32'h2);
         chk("seq_owner", 32'(bus.owner), 1);
         chk("seq_count", 32'(bus.count), 32'((i + 1) % 5));
         chk("seq_trig", 32'(bus.trigger), (i == 3) ? 1 : 0);
         step(8);
      end
      // contention 0,2,3 then 0+3
      do_reset();
      bus.req = 4'b1101;
      step(2);
      chk("cont_g0", 32'(bus.grant), 32'h1);
      bus.req = '0;
      step(2);
      chk("cont_gap", 32'(bus.grant), 0);
      step(2);
      chk("cont_g2", 32'(bus.grant), 32'h4);
      step(4);
      chk("cont_g3", 32'(bus.grant), 32'h8);
      chk("cont_cnt3", 32'(bus.count), 3);
      step(4);
      bus.req = 4'b1001;
      step(2);
      chk("cont_g0b", 32'(bus.grant), 32'h1);
      chk("cont_cnt4", 32'(bus.count), 4);
      chk("cont_trig4", 32'(bus.trigger), 1);
      bus.req = '0;
      step(4);
      chk("cont_g3b", 32'(bus.grant), 32'h8);
      chk("cont_wrap", 32'(bus.count), 0);
      chk("cont_trig0", 32'(bus.trigger), 0);
      // merge during cooldown
      do_reset();
      bus.req = 4'b0001;
      step(1);
      bus.req = '0;
      step(1);
      chk("merge_g0", 32'(bus.grant), 32'h1);
      bus.req = 4'b0100;
      step(1);
      chk("merge_nodrop", 32'(bus.drop), 0);
      bus.req = '0;
      step(1);
      bus.req = 4'b0100;
      step(1);
      chk("merge_drop", 32'(bus.drop), 1);
      bus.req = '0;
      step(1);
      chk("merge_drop_end", 32'(bus.drop), 0);
      chk("merge_g2", 32'(bus.grant), 32'h4);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         hits += int'(bus.grant != '0);
      end
      chk("merge_extra", 32'(hits), 0);
      // held button
      do_reset();
      bus.req = 4'b0010;
      hits = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         hits += int'(bus.grant[1]);
      end
      chk("held_grants", 32'(hits), 1);
      bus.req = '0;
      // async reset mid-cooldown
      do_reset();
      for (int i = 0; i < 2; i++) begin
         bus.req = 4'b0001;
         step(1);
         bus.req = '0;
         step(5);
      end
      bus.req = 4'b0001;
      step(1);
      bus.req = '0;
      step(1);
      bus.req = 4'b0110;
      step(1);
      chk("ar_pre_count", 32'(bus.count), 3);
      chk("ar_pre_busy", 32'(bus.busy), 1);
      reset = 1'b0;
      #1;
      chk("ar_count", 32'(bus.count), 0);
      chk("ar_busy", 32'(bus.busy), 0);
      chk("ar_owner", 32'(bus.owner), 0);
      chk("ar_grant", 32'(bus.grant), 0);
      bus.req = '0;
      step(1);
      reset = 1'b1;
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         hits += int'(bus.grant != '0);
      end
      chk("ar_no_grant", 32'(hits), 0);
      bus.req = 4'b0100;
      step(2);
      chk("ar_new_grant", 32'(bus.grant), 32'h4);
      chk("ar_new_count", 32'(bus.count), 1);
      chk("ar_new_owner", 32'(bus.owner), 2);
      bus.req = '0;
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
